// File: rtl/timer_pkg.sv
// Shared register indices and bit positions for the APB timer core.
package timer_pkg;

  localparam int TIMER_NUM_REGS = 5;

  localparam int CTRL_IDX     = 0;
  localparam int PRESCALE_IDX = 1;
  localparam int COUNT_IDX    = 2;
  localparam int COMPARE_IDX  = 3;
  localparam int STATUS_IDX   = 4;

  localparam int EN_BIT = 0;
  localparam int AR_BIT = 1;
  localparam int IE_BIT = 2;
  localparam int OS_BIT = 3;

  localparam int MATCH_BIT = 0;
  localparam int OVF_BIT   = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider that emits a single-cycle tick every div+1 clocks while enabled.
module timer_prescaler #(
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] r_preCnt;

  assign tick = en && !clr && (r_preCnt == div);

  // A divider rewrite restarts the period so the new value takes effect cleanly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_preCnt <= '0;
    end else if (!en || clr || tick) begin
      r_preCnt <= '0;
    end else begin
      r_preCnt <= r_preCnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_timer_core.sv
// Timer register bank and counting engine: prescaled 32-bit up-counter with
// compare match, overflow, auto-reload, one-shot and a level interrupt.
module apb_timer_core
  import timer_pkg::*;
#(
  parameter int NUM_REGS  = TIMER_NUM_REGS,
  parameter int PRE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NUM_REGS-1:0]      w_enable,
  input  logic [NUM_REGS-1:0]      r_enable,
  input  logic [31:0]              w_data,
  output logic [NUM_REGS-1:0][31:0] read_data,
  output logic                     timer_irq
);

  logic [3:0]           r_ctrl;
  logic [PRE_WIDTH-1:0] r_prescale;
  logic [31:0]          r_count;
  logic [31:0]          r_compare;
  logic [1:0]           r_status;

  logic        w_tick;
  logic        w_countWr;
  logic        w_matchEv;
  logic        w_ovfEv;
  logic [1:0]  w_statusClr;
  logic [31:0] w_countNext;
  logic        w_unused;

  assign w_unused = ^r_enable;

  timer_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_prescaler (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (r_ctrl[EN_BIT]),
    .clr   (w_enable[PRESCALE_IDX]),
    .div   (r_prescale),
    .tick  (w_tick)
  );

  // A software COUNT write swallows a coincident tick, including its flags.
  assign w_countWr   = w_enable[COUNT_IDX];
  assign w_matchEv   = w_tick && !w_countWr && (r_count == r_compare);
  assign w_ovfEv     = w_tick && !w_countWr && (r_count != r_compare) && (r_count == 32'hFFFF_FFFF);
  assign w_statusClr = w_enable[STATUS_IDX] ? w_data[1:0] : 2'b00;

  always_comb begin
    w_countNext = r_count;
    if (w_countWr) begin
      w_countNext = w_data;
    end else if (w_matchEv) begin
      w_countNext = r_ctrl[AR_BIT] ? 32'd0 : r_count + 32'd1;
    end else if (w_tick) begin
      w_countNext = r_count + 32'd1;
    end
  end

  // One-shot drops EN on match unless software rewrites CTRL in that same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_status   <= '0;
    end else begin
      if (w_enable[CTRL_IDX]) begin
        r_ctrl <= w_data[3:0];
      end else if (w_matchEv && r_ctrl[OS_BIT]) begin
        r_ctrl[EN_BIT] <= 1'b0;
      end
      if (w_enable[PRESCALE_IDX]) begin
        r_prescale <= w_data[PRE_WIDTH-1:0];
      end
      if (w_enable[COMPARE_IDX]) begin
        r_compare <= w_data;
      end
      r_count  <= w_countNext;
      r_status <= (r_status & ~w_statusClr) | {w_ovfEv, w_matchEv};
    end
  end

  always_comb begin
    read_data                              = '0;
    read_data[CTRL_IDX][3:0]               = r_ctrl;
    read_data[PRESCALE_IDX][PRE_WIDTH-1:0] = r_prescale;
    read_data[COUNT_IDX]                   = r_count;
    read_data[COMPARE_IDX]                 = r_compare;
    read_data[STATUS_IDX][1:0]             = r_status;
  end

  assign timer_irq = r_ctrl[IE_BIT] && (r_status[MATCH_BIT] || r_status[OVF_BIT]);

endmodule

// File: tb/tb_apb_timer_core.sv
// Scoreboard bench for apb_timer_core: directed register writes queue expected
// read-back values that a negedge monitor pops and compares.
module tb_apb_timer_core;
  import timer_pkg::*;

  localparam int IRQ_SEL = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } expT;

  logic             clk;
  logic             nRst;
  logic [4:0]       wEnable;
  logic [4:0]       rEnable;
  logic [31:0]      wData;
  logic [4:0][31:0] readData;
  logic             timerIrq;

  expT         scoreQ[$];
  logic        chkFlag;
  int          checkCount;
  int          failCount;
  expT         monEntry;
  logic [31:0] monActual;

  apb_timer_core dut (
    .clk       (clk),
    .n_rst     (nRst),
    .w_enable  (wEnable),
    .r_enable  (rEnable),
    .w_data    (wData),
    .read_data (readData),
    .timer_irq (timerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drains every queued expectation whenever the stimulus requests a sample.
  always @(negedge clk) begin
    if (chkFlag) begin
      while (scoreQ.size() > 0) begin
        monEntry  = scoreQ.pop_front();
        monActual = (monEntry.sel == IRQ_SEL) ? {31'b0, timerIrq} : readData[monEntry.sel];
        checkCount++;
        if (monActual !== monEntry.exp) begin
          failCount++;
          $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                   monEntry.name, monActual, monEntry.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] data);
    wEnable      = '0;
    wEnable[idx] = 1'b1;
    wData        = data;
    @(posedge clk);
    #1;
    wEnable = '0;
    wData   = '0;
  endtask

  task automatic expectVal(input string name, input int sel, input logic [31:0] exp);
    expT e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput();
    chkFlag = 1'b1;
    @(negedge clk);
    #1;
    chkFlag = 1'b0;
  endtask

  task automatic disableAndClear(input string name);
    applyStimulus(CTRL_IDX, 32'h0);
    applyStimulus(STATUS_IDX, 32'h3);
    applyStimulus(COUNT_IDX, 32'h0);
    expectVal({name, "_statusCleared"}, STATUS_IDX, 32'h0);
    expectVal({name, "_countCleared"}, COUNT_IDX, 32'h0);
    checkOutput();
  endtask

  initial begin
    nRst       = 1'b0;
    wEnable    = '0;
    rEnable    = '0;
    wData      = '0;
    chkFlag    = 1'b0;
    checkCount = 0;
    failCount  = 0;

    // Reset state
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) expectVal($sformatf("resetReg%0d", i), i, 32'h0);
    expectVal("resetIrq", IRQ_SEL, 32'h0);
    checkOutput();
    nRst = 1'b1;
    idle(1);

    $display("[TB] basic count");
    applyStimulus(PRESCALE_IDX, 32'd0);
    applyStimulus(COMPARE_IDX, 32'd3);
    applyStimulus(CTRL_IDX, 32'h3);
    for (int i = 0; i < 4; i++) begin
      expectVal($sformatf("basicCount%0d", i), COUNT_IDX, i);
      expectVal($sformatf("basicNoMatch%0d", i), STATUS_IDX, 32'h0);
      checkOutput();
      idle(1);
    end
    expectVal("basicWrapCount", COUNT_IDX, 32'h0);
    expectVal("basicMatchSet", STATUS_IDX, 32'h1);
    expectVal("basicIrqMasked", IRQ_SEL, 32'h0);
    expectVal("basicCtrl", CTRL_IDX, 32'h3);
    checkOutput();
    disableAndClear("basic");

    $display("[TB] prescale and interrupt");
    applyStimulus(PRESCALE_IDX, 32'd4);
    applyStimulus(COMPARE_IDX, 32'd1);
    applyStimulus(CTRL_IDX, 32'h7);
    expectVal("prescaleReadback", PRESCALE_IDX, 32'd4);
    checkOutput();
    idle(9);
    expectVal("preBeforeMatchCount", COUNT_IDX, 32'd1);
    expectVal("preBeforeMatchStatus", STATUS_IDX, 32'h0);
    expectVal("preBeforeMatchIrq", IRQ_SEL, 32'h0);
    checkOutput();
    idle(1);
    expectVal("preMatchCount", COUNT_IDX, 32'd0);
    expectVal("preMatchStatus", STATUS_IDX, 32'h1);
    expectVal("preMatchIrq", IRQ_SEL, 32'h1);
    checkOutput();
    applyStimulus(STATUS_IDX, 32'h1);
    expectVal("preW1cStatus", STATUS_IDX, 32'h0);
    expectVal("preW1cIrq", IRQ_SEL, 32'h0);
    checkOutput();
    disableAndClear("prescale");

    $display("[TB] overflow");
    applyStimulus(PRESCALE_IDX, 32'd0);
    applyStimulus(COMPARE_IDX, 32'd0);
    applyStimulus(COUNT_IDX, 32'hFFFF_FFFE);
    applyStimulus(CTRL_IDX, 32'h5);
    idle(1);
    expectVal("ovfMaxCount", COUNT_IDX, 32'hFFFF_FFFF);
    expectVal("ovfMaxStatus", STATUS_IDX, 32'h0);
    checkOutput();
    idle(1);
    expectVal("ovfWrapCount", COUNT_IDX, 32'h0);
    expectVal("ovfStatus", STATUS_IDX, 32'h2);
    expectVal("ovfIrq", IRQ_SEL, 32'h1);
    checkOutput();
    disableAndClear("overflow");

    $display("[TB] one-shot");
    applyStimulus(COMPARE_IDX, 32'd2);
    applyStimulus(CTRL_IDX, 32'hB);
    idle(3);
    expectVal("osCount", COUNT_IDX, 32'h0);
    expectVal("osCtrlEnCleared", CTRL_IDX, 32'hA);
    expectVal("osMatch", STATUS_IDX, 32'h1);
    checkOutput();
    idle(20);
    expectVal("osCountHeld", COUNT_IDX, 32'h0);
    expectVal("osCtrlHeld", CTRL_IDX, 32'hA);
    checkOutput();
    disableAndClear("oneShot");

    $display("[TB] count write collides with tick");
    applyStimulus(COMPARE_IDX, 32'd0);
    applyStimulus(CTRL_IDX, 32'h1);
    applyStimulus(COUNT_IDX, 32'h100);
    expectVal("collCountWins", COUNT_IDX, 32'h100);
    expectVal("collNoFlag", STATUS_IDX, 32'h0);
    checkOutput();
    disableAndClear("collision");

    $display("[TB] status clear collides with match");
    applyStimulus(COMPARE_IDX, 32'd1);
    applyStimulus(CTRL_IDX, 32'h7);
    idle(2);
    expectVal("w1cFirstMatch", STATUS_IDX, 32'h1);
    expectVal("w1cFirstIrq", IRQ_SEL, 32'h1);
    checkOutput();
    applyStimulus(STATUS_IDX, 32'h1);
    expectVal("w1cPlainClear", STATUS_IDX, 32'h0);
    expectVal("w1cPlainIrq", IRQ_SEL, 32'h0);
    checkOutput();
    applyStimulus(STATUS_IDX, 32'h1);
    expectVal("w1cSetWins", STATUS_IDX, 32'h1);
    expectVal("w1cSetWinsIrq", IRQ_SEL, 32'h1);
    expectVal("w1cReloadCount", COUNT_IDX, 32'h0);
    checkOutput();

    $display("[TB] reset mid-run");
    idle(1);
    nRst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) expectVal($sformatf("midResetReg%0d", i), i, 32'h0);
    expectVal("midResetIrq", IRQ_SEL, 32'h0);
    checkOutput();
    nRst = 1'b1;
    idle(3);
    expectVal("postResetCtrl", CTRL_IDX, 32'h0);
    expectVal("postResetCountIdle", COUNT_IDX, 32'h0);
    expectVal("postResetStatus", STATUS_IDX, 32'h0);
    checkOutput();

    if (scoreQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", scoreQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
